button_reader: RTL and testbench
================================

# button_reader

Memory-mapped input peripheral for the front-panel push buttons, on the picorv32 native memory bus beside the LED output register and the UART. Synchronizes and debounces each button, keeps live debounced levels and sticky press events, and raises a level interrupt for enabled events. It is the read-side counterpart of the LED writer: the CPU polls or takes an interrupt instead of driving pins.

## Interface
- N_BUTTONS, 2: number of button inputs, 1..8.
- DEBOUNCE_CYCLES, 125000: cycles a changed input must stay stable before it is accepted (1 ms at 125 MHz); minimum 2.
- CNT_W, 17: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

- clk  in  1  system clock (CLK_OUT1 domain).
- resetn  in  1  synchronous, active-low reset.
- buttons_i  in  N_BUTTONS  raw asynchronous button pins, active-high (1 = pressed).
- reg_sel  in  1  bus select, decoded by top from mem_valid and address; held until reg_ready.
- reg_addr  in  2  word address, mem_addr[3:2].
- reg_wstrb  in  4  byte strobes; 0 = read.
- reg_wdata  in  32  write data.
- reg_rdata  out  32  read data, valid while reg_ready = 1.
- reg_ready  out  1  one-cycle transfer acknowledge.
- irq  out  1  level interrupt, high while any enabled event bit is set.

## Operation
- Per button: 2-flop synchronizer -> debounce counter -> debounced level `state[i]`.
- Debounce: if sync[i] == state[i], counter clears to 0. Otherwise the counter increments. When the counter equals DEBOUNCE_CYCLES-1 and sync[i] still differs, state[i] takes sync[i] and the counter clears. Any bounce back to equality clears the counter.
- Press event: a 0->1 transition of state[i] sets event[i]. Release sets nothing.
- Registers (unused bits read 0; writes to them ignored):
  - addr 0, STATE, RO: bits[N-1:0] = state.
  - addr 1, EVENT, W1C: bits[N-1:0] = event. Write 1 clears, write 0 has no effect. Only reg_wstrb[0] is honoured.
  - addr 2, IRQEN, RW: bits[N-1:0] = mask. Only reg_wstrb[0] is honoured.
  - addr 3: reads 0, writes ignored.
- irq = |(event & mask), registered.
- Simultaneous press event and W1C on the same bit: set wins; the bit stays 1.
- Reads have no side effects.

## Timing
- Reset values (resetn = 0 at a clk edge): sync flops, state, counters, event, mask = 0. reg_ready = 0, reg_rdata = 0, irq = 0. Reset mid-debounce discards progress. Reset during a bus access drops it: no ready.
- Bus handshake, two-state FSM IDLE/ACK:
  - IDLE & reg_sel -> ACK. On that edge, capture reg_rdata and perform the write.
  - ACK: reg_ready = 1 for exactly one cycle, then back to IDLE.
  - reg_ready is never high two consecutive cycles; back-to-back accesses take 2 cycles each.
  - reg_sel low in IDLE: reg_rdata returns to 0.
- Latency: a clean input edge at cycle 0 (sampled by sync stage 1) makes state change at the end of cycle DEBOUNCE_CYCLES+1. event sets 1 cycle later. irq rises 1 cycle after that.
- After an EVENT W1C access: event bit is 0 in the cycle reg_ready is high. irq falls one cycle later.
- Inputs that change for fewer than DEBOUNCE_CYCLES consecutive synchronized cycles never change state.

## Test plan
All tests use DEBOUNCE_CYCLES = 4, N_BUTTONS = 2.

- Reset: hold resetn = 0 with buttons_i = 2'b11 for 3 cycles -> reg_ready, irq, reg_rdata = 0. Read STATE right after release -> 0.
- Clean press: buttons_i[0] 0->1 and held -> state[0] = 1 exactly 6 cycles after the edge. Read EVENT -> 0x1. With IRQEN = 0x1, irq = 1 at 8 cycles.
- Bounce: toggle buttons_i[1] as 1,1,1,0,1,1,1,0 repeatedly -> state[1] stays 0, EVENT stays 0. Then hold 1 -> state[1] = 1 after 4 stable synchronized cycles.
- W1C collision: press event on bit 0 arrives in the same cycle as a write of 0x1 to EVENT -> EVENT reads 0x1 afterwards. Write 0x1 again with no event -> reads 0x0 and irq drops one cycle later.
- Bus protocol: reg_sel held high for 6 cycles -> reg_ready pattern 0,1,0,1,0,1. Write 0xFFFFFFFF to IRQEN, read back -> 0x00000003. Read addr 3 -> 0.
- Reset mid-operation: assert resetn = 0 while a debounce counter is at 2 and event = 0x2 -> all cleared. After release with the button still held, state re-asserts 6 cycles later and EVENT = 0x2 again.

Source files
------------

// File: rtl/button_reader.sv
// Front-panel button input peripheral for the picorv32 native memory bus.
// Each button is synchronized, debounced into a live level, and its presses
// are latched as sticky events that the CPU can poll, clear or take as an
// interrupt.
//
// Register map (word address reg_addr):
//   0 STATE  RO   debounced button levels
//   1 EVENT  W1C  sticky press events (byte-lane 0 strobe only)
//   2 IRQEN  RW   interrupt mask for EVENT (byte-lane 0 strobe only)
//   3 --     reads 0, writes ignored
module button_reader #(
  parameter int N_BUTTONS       = 2,
  parameter int DEBOUNCE_CYCLES = 125000,
  parameter int CNT_W           = 17
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [N_BUTTONS-1:0] buttons_i,
  input  logic                 reg_sel,
  input  logic [1:0]           reg_addr,
  input  logic [3:0]           reg_wstrb,
  input  logic [31:0]          reg_wdata,
  output logic [31:0]          reg_rdata,
  output logic                 reg_ready,
  output logic                 irq
);

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } bus_state_t;

  localparam logic [1:0]       ADDR_STATE = 2'd0;
  localparam logic [1:0]       ADDR_EVENT = 2'd1;
  localparam logic [1:0]       ADDR_IRQEN = 2'd2;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_BUTTONS-1:0] sync_q1;
  logic [N_BUTTONS-1:0] sync_q2;
  logic [N_BUTTONS-1:0] state_q;
  logic [N_BUTTONS-1:0] state_dly;
  logic [N_BUTTONS-1:0] event_q;
  logic [N_BUTTONS-1:0] mask_q;
  logic [N_BUTTONS-1:0] press;
  logic [N_BUTTONS-1:0] event_clr;
  logic [CNT_W-1:0]     cnt_q [N_BUTTONS];

  bus_state_t           bus_state;
  bus_state_t           bus_next;
  logic                 bus_accept;
  logic                 wr_event;
  logic                 wr_mask;
  logic [31:0]          rdata_mux;

  // Upper write-data bits and strobes 3..1 address no storage.
  logic                 unused_wr_bits;
  assign unused_wr_bits = &{1'b0, reg_wdata[31:N_BUTTONS], reg_wstrb[3:1]};

  // Two-flop synchronizer for the asynchronous button pins.
  always_ff @(posedge clk) begin
    // NOTE: every clocked block uses non-blocking assignments so all flops
    // sample their inputs from before the edge, independent of block order.
    if (!resetn) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= buttons_i;
      sync_q2 <= sync_q1;
    end
  end

  // Debounce: a synchronized level that differs from the accepted level for
  // DEBOUNCE_CYCLES consecutive cycles becomes the new accepted level.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= '0;
      // NOTE: the counter array is plain flops, not a RAM, and is cleared so
      // that a reset in the middle of a debounce window discards the progress.
      for (int i = 0; i < N_BUTTONS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_BUTTONS; i++) begin
        if (sync_q2[i] == state_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          state_q[i] <= sync_q2[i];
          cnt_q[i]   <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // A press is a 0->1 step of the debounced level; releases are not recorded.
  assign press = state_q & ~state_dly;

  // Bus handshake: accept in IDLE, acknowledge for exactly one cycle in ACK.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      bus_state <= IDLE;
    end else begin
      bus_state <= bus_next;
    end
  end

  // Next-state and handshake outputs for the bus FSM.
  always_comb begin
    // NOTE: defaults first, so no path through the case leaves a signal
    // unassigned and no latch is inferred.
    bus_next   = bus_state;
    bus_accept = 1'b0;
    reg_ready  = 1'b0;
    case (bus_state)
      IDLE: begin
        if (reg_sel) begin
          bus_next   = ACK;
          bus_accept = 1'b1;
        end
      end
      ACK: begin
        reg_ready = 1'b1;
        bus_next  = IDLE;
      end
      default: bus_next = IDLE;
    endcase
  end

  assign wr_event = bus_accept && reg_wstrb[0] && (reg_addr == ADDR_EVENT);
  assign wr_mask  = bus_accept && reg_wstrb[0] && (reg_addr == ADDR_IRQEN);

  // W1C clear mask for the event register, active only on an accepted write.
  always_comb begin
    event_clr = '0;
    if (wr_event) begin
      event_clr = reg_wdata[N_BUTTONS-1:0];
    end
  end

  // Read data selection; unused bits and address 3 read as zero.
  always_comb begin
    rdata_mux = '0;
    case (reg_addr)
      ADDR_STATE: rdata_mux[N_BUTTONS-1:0] = state_q;
      ADDR_EVENT: rdata_mux[N_BUTTONS-1:0] = event_q;
      ADDR_IRQEN: rdata_mux[N_BUTTONS-1:0] = mask_q;
      default:    rdata_mux = '0;
    endcase
  end

  // Sticky events (a new press beats a simultaneous clear), mask, and irq.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_dly <= '0;
      event_q   <= '0;
      mask_q    <= '0;
      irq       <= 1'b0;
    end else begin
      state_dly <= state_q;
      event_q   <= (event_q & ~event_clr) | press;
      if (wr_mask) begin
        mask_q <= reg_wdata[N_BUTTONS-1:0];
      end
      irq <= |(event_q & mask_q);
    end
  end

  // Read data is captured at accept, held through ACK, and zero when idle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      reg_rdata <= '0;
    end else if (bus_accept) begin
      reg_rdata <= rdata_mux;
    end else if (bus_state == IDLE) begin
      reg_rdata <= '0;
    end
  end

endmodule

// File: tb/tb_button_reader.sv
// Self-checking bench for button_reader with a 4-cycle debounce window.
// Directed scenarios check fixed latencies and register behaviour; a random
// phase compares the bus outputs against a behavioural model every cycle.
module tb_button_reader;

  localparam int N = 2;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic [N-1:0]  buttons;
  logic          reg_sel;
  logic [1:0]    reg_addr;
  logic [3:0]    reg_wstrb;
  logic [31:0]   reg_wdata;
  logic [31:0]   reg_rdata;
  logic          reg_ready;
  logic          irq;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  button_reader #(
    .N_BUTTONS      (N),
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (3)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .buttons_i(buttons),
    .reg_sel  (reg_sel),
    .reg_addr (reg_addr),
    .reg_wstrb(reg_wstrb),
    .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata),
    .reg_ready(reg_ready),
    .irq      (irq)
  );

  // Behavioural model: a level is accepted once the last D synchronized
  // samples all disagree with the current level (sliding window).
  typedef struct packed {
    logic [N-1:0]        s1;
    logic [N-1:0]        s2;
    logic [N-1:0][D-1:0] hist;
    logic [N-1:0]        st;
    logic [N-1:0]        st_old;
    logic [N-1:0]        ev;
    logic [N-1:0]        mask;
    logic                irq;
    logic                busy;
    logic [31:0]         rdata;
  } model_t;

  model_t m;

  function automatic logic [31:0] model_read(model_t c, logic [1:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      2'd0:    r[N-1:0] = c.st;
      2'd1:    r[N-1:0] = c.ev;
      2'd2:    r[N-1:0] = c.mask;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic model_t model_next(model_t c, logic [N-1:0] btn, logic sel,
                                        logic [1:0] a, logic [3:0] ws, logic [31:0] wd);
    model_t     n;
    logic       accept;
    logic [N-1:0] clr;
    n      = c;
    accept = !c.busy && sel;
    clr    = '0;
    n.s1   = btn;
    n.s2   = c.s1;
    for (int i = 0; i < N; i++) begin
      n.hist[i] = {c.hist[i][D-2:0], c.s2[i]};
      if (n.hist[i] == {D{~c.st[i]}}) n.st[i] = c.s2[i];
    end
    if (accept && ws[0] && a == 2'd1) clr = wd[N-1:0];
    if (accept && ws[0] && a == 2'd2) n.mask = wd[N-1:0];
    n.st_old = c.st;
    n.ev     = (c.ev & ~clr) | (c.st & ~c.st_old);
    n.irq    = |(c.ev & c.mask);
    n.busy   = accept;
    n.rdata  = accept ? model_read(c, a) : (c.busy ? c.rdata : 32'h0);
    return n;
  endfunction

  always @(posedge clk) begin
    m <= resetn ? model_next(m, buttons, reg_sel, reg_addr, reg_wstrb, reg_wdata) : '0;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one access from the current negedge; the capture happens on the
  // next accepting edge and the task returns on the negedge where ready is seen.
  task automatic bus_access(input logic [1:0] a, input logic [3:0] ws,
                            input logic [31:0] wd, output logic [31:0] rd);
    logic got;
    got       = 1'b0;
    rd        = '0;
    reg_sel   = 1'b1;
    reg_addr  = a;
    reg_wstrb = ws;
    reg_wdata = wd;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      if (reg_ready === 1'b1) begin
        rd  = reg_rdata;
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL bus_timeout addr=%0d: reg_ready=%b after 4 cycles, required 1", a, reg_ready);
    end
    reg_sel   = 1'b0;
    reg_wstrb = 4'h0;
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    resetn  = 1'b0;
    buttons = '1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (reg_ready !== 1'b0 || irq !== 1'b0 || reg_rdata !== 32'h0) begin
        n_err++;
        $display("FAIL reset_outputs cycle %0d: ready=%b irq=%b rdata=%h, required 0 0 00000000",
                 c, reg_ready, irq, reg_rdata);
      end
    end
    buttons = '0;
    resetn  = 1'b1;
    bus_access(2'd0, 4'h0, 32'h0, rd);
    n_cmp++;
    if (rd !== 32'h0) begin
      n_err++;
      $display("FAIL reset_state_read: got %h, required 00000000", rd);
    end
  endtask

  task automatic test_clean_press;
    logic [31:0] rd;
    bus_access(2'd2, 4'h1, 32'h1, rd);
    buttons[0] = 1'b1;
    cycles(5);
    bus_access(2'd0, 4'h0, 32'h0, rd);
    n_cmp++;
    if (rd !== 32'h0) begin
      n_err++;
      $display("FAIL press_state_edge5: got %h, required 00000000", rd);
    end
    cycles(4);
    buttons[0] = 1'b0;
    cycles(10);
    bus_access(2'd1, 4'h0, 32'h0, rd);
    n_cmp++;
    if (rd !== 32'h1) begin
      n_err++;
      $display("FAIL press_event: got %h, required 00000001", rd);
    end
    bus_access(2'd1, 4'h1, 32'h1, rd);
    cycles(2);
    buttons[0] = 1'b1;
    cycles(6);
    bus_access(2'd0, 4'h0, 32'h0, rd);
    n_cmp++;
    if (rd !== 32'h1) begin
      n_err++;
      $display("FAIL press_state_edge6: got %h, required 00000001", rd);
    end
    n_cmp++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL press_irq_cycle7: got %b, required 0", irq);
    end
    @(negedge clk);
    n_cmp++;
    if (irq !== 1'b1) begin
      n_err++;
      $display("FAIL press_irq_cycle8: got %b, required 1", irq);
    end
    buttons[0] = 1'b0;
    cycles(10);
    bus_access(2'd1, 4'h1, 32'h1, rd);
    cycles(2);
  endtask

  task automatic test_bounce;
    logic [31:0] rd;
    logic [3:0]  pat;
    pat = 4'b0111;
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 4; k++) begin
        buttons[1] = pat[k];
        @(negedge clk);
      end
    end
    bus_access(2'd0, 4'h0, 32'h0, rd);
    n_cmp++;
    if (rd !== 32'h0) begin
      n_err++;
      $display("FAIL bounce_state: got %h, required 00000000", rd);
    end
    bus_access(2'd1, 4'h0, 32'h0, rd);
    n_cmp++;
    if (rd !== 32'h0) begin
      n_err++;
      $display("FAIL bounce_event: got %h, required 00000000", rd);
    end
    buttons[1] = 1'b1;
    cycles(5);
    bus_access(2'd0, 4'h0, 32'h0, rd);
    n_cmp++;
    if (rd !== 32'h0) begin
      n_err++;
      $display("FAIL bounce_hold_early: got %h, required 00000000", rd);
    end
    bus_access(2'd0, 4'h0, 32'h0, rd);
    n_cmp++;
    if (rd !== 32'h2) begin
      n_err++;
      $display("FAIL bounce_hold_accept: got %h, required 00000002", rd);
    end
    buttons[1] = 1'b0;
    cycles(10);
    bus_access(2'd1, 4'h1, 32'h3, rd);
    cycles(2);
  endtask

  task automatic test_w1c_collision;
    logic [31:0] rd;
    buttons[0] = 1'b1;
    cycles(6);
    bus_access(2'd1, 4'h1, 32'h1, rd);
    bus_access(2'd1, 4'h0, 32'h0, rd);
    n_cmp++;
    if (rd !== 32'h1) begin
      n_err++;
      $display("FAIL collision_set_wins: got %h, required 00000001", rd);
    end
    bus_access(2'd1, 4'h1, 32'h1, rd);
    n_cmp++;
    if (irq !== 1'b1) begin
      n_err++;
      $display("FAIL w1c_irq_ready_cycle: got %b, required 1", irq);
    end
    @(negedge clk);
    n_cmp++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL w1c_irq_fall: got %b, required 0", irq);
    end
    bus_access(2'd1, 4'h0, 32'h0, rd);
    n_cmp++;
    if (rd !== 32'h0) begin
      n_err++;
      $display("FAIL w1c_cleared: got %h, required 00000000", rd);
    end
    buttons[0] = 1'b0;
    cycles(10);
  endtask

  task automatic test_bus_protocol;
    logic [31:0] rd;
    logic        exp_ready;
    reg_sel   = 1'b1;
    reg_addr  = 2'd0;
    reg_wstrb = 4'h0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      exp_ready = (c % 2) == 1;
      n_cmp++;
      if (reg_ready !== exp_ready) begin
        n_err++;
        $display("FAIL ready_pattern cycle %0d: got %b, required %b", c, reg_ready, exp_ready);
      end
    end
    reg_sel = 1'b0;
    @(negedge clk);
    bus_access(2'd2, 4'hF, 32'hFFFF_FFFF, rd);
    bus_access(2'd2, 4'h0, 32'h0, rd);
    n_cmp++;
    if (rd !== 32'h3) begin
      n_err++;
      $display("FAIL irqen_readback: got %h, required 00000003", rd);
    end
    cycles(2);
    n_cmp++;
    if (reg_rdata !== 32'h0) begin
      n_err++;
      $display("FAIL rdata_idle_zero: got %h, required 00000000", reg_rdata);
    end
    bus_access(2'd2, 4'h2, 32'h0, rd);
    bus_access(2'd2, 4'h0, 32'h0, rd);
    n_cmp++;
    if (rd !== 32'h3) begin
      n_err++;
      $display("FAIL irqen_lane0_only: got %h, required 00000003", rd);
    end
    bus_access(2'd3, 4'hF, 32'hFFFF_FFFF, rd);
    bus_access(2'd3, 4'h0, 32'h0, rd);
    n_cmp++;
    if (rd !== 32'h0) begin
      n_err++;
      $display("FAIL addr3_reads_zero: got %h, required 00000000", rd);
    end
    bus_access(2'd0, 4'hF, 32'hFFFF_FFFF, rd);
    bus_access(2'd0, 4'h0, 32'h0, rd);
    n_cmp++;
    if (rd !== 32'h0) begin
      n_err++;
      $display("FAIL state_read_only: got %h, required 00000000", rd);
    end
    bus_access(2'd2, 4'h1, 32'h0, rd);
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd;
    bus_access(2'd2, 4'h1, 32'h2, rd);
    buttons[1] = 1'b1;
    cycles(12);
    buttons[1] = 1'b0;
    cycles(10);
    bus_access(2'd1, 4'h0, 32'h0, rd);
    n_cmp++;
    if (rd !== 32'h2 || irq !== 1'b1) begin
      n_err++;
      $display("FAIL mid_preconditions: event=%h irq=%b, required 00000002 1", rd, irq);
    end
    buttons[1] = 1'b1;
    cycles(4);
    resetn   = 1'b0;
    reg_sel  = 1'b1;
    reg_addr = 2'd1;
    @(negedge clk);
    n_cmp++;
    if (reg_ready !== 1'b0 || irq !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_outputs: ready=%b irq=%b, required 0 0", reg_ready, irq);
    end
    @(negedge clk);
    n_cmp++;
    if (reg_ready !== 1'b0 || reg_rdata !== 32'h0) begin
      n_err++;
      $display("FAIL mid_reset_drop: ready=%b rdata=%h, required 0 00000000", reg_ready, reg_rdata);
    end
    reg_sel = 1'b0;
    resetn  = 1'b1;
    bus_access(2'd1, 4'h0, 32'h0, rd);
    n_cmp++;
    if (rd !== 32'h0) begin
      n_err++;
      $display("FAIL mid_event_cleared: got %h, required 00000000", rd);
    end
    bus_access(2'd2, 4'h0, 32'h0, rd);
    n_cmp++;
    if (rd !== 32'h0) begin
      n_err++;
      $display("FAIL mid_mask_cleared: got %h, required 00000000", rd);
    end
    bus_access(2'd0, 4'h0, 32'h0, rd);
    n_cmp++;
    if (rd !== 32'h0) begin
      n_err++;
      $display("FAIL mid_state_early: got %h, required 00000000", rd);
    end
    bus_access(2'd0, 4'h0, 32'h0, rd);
    n_cmp++;
    if (rd !== 32'h2) begin
      n_err++;
      $display("FAIL mid_state_reassert: got %h, required 00000002", rd);
    end
    bus_access(2'd1, 4'h0, 32'h0, rd);
    n_cmp++;
    if (rd !== 32'h2 || irq !== 1'b0) begin
      n_err++;
      $display("FAIL mid_event_again: event=%h irq=%b, required 00000002 0", rd, irq);
    end
    buttons[1] = 1'b0;
    cycles(10);
    bus_access(2'd1, 4'h1, 32'h3, rd);
    cycles(2);
  endtask

  task automatic test_random;
    int hold [N];
    for (int b = 0; b < N; b++) hold[b] = 0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      n_cmp++;
      if (reg_ready !== m.busy || irq !== m.irq || reg_rdata !== m.rdata) begin
        n_err++;
        $display("FAIL random_cycle %0d: ready=%b irq=%b rdata=%h, required %b %b %h",
                 c, reg_ready, irq, reg_rdata, m.busy, m.irq, m.rdata);
      end
      for (int b = 0; b < N; b++) begin
        if (hold[b] == 0) begin
          buttons[b] = 1'($urandom_range(0, 1));
          hold[b]    = $urandom_range(1, 7);
        end else begin
          hold[b]--;
        end
      end
      if (reg_sel && m.busy) begin
        reg_sel   = 1'b0;
        reg_wstrb = 4'h0;
      end else if (!reg_sel && $urandom_range(0, 2) == 0) begin
        reg_sel   = 1'b1;
        reg_addr  = 2'($urandom_range(0, 3));
        reg_wstrb = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
        reg_wdata = $urandom;
      end
    end
    reg_sel   = 1'b0;
    reg_wstrb = 4'h0;
    buttons   = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn    = 1'b0;
    buttons   = '0;
    reg_sel   = 1'b0;
    reg_addr  = 2'd0;
    reg_wstrb = 4'h0;
    reg_wdata = 32'h0;
    test_reset;
    test_clean_press;
    test_bounce;
    test_w1c_collision;
    test_bus_protocol;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
